// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the memory port arbiter.
//                Arbitration state, read-return owner, read tag record and
//                the full-word byte-enable constant.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    // Which requester wins when both are active.
    typedef enum logic [0:0] {
        DATA_PRI  = 1'b0,
        FETCH_PRI = 1'b1
    } arb_state_e;

    // Owner of an in-flight read.
    typedef enum logic [0:0] {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    // One entry of the read-return tag pipeline.
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

    // Byte enables for a full-word read.
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/rd_tag_pipe.sv
// ============================================================================
//  Module      : rd_tag_pipe
//  Description : Fixed-depth shift register of read tags. One entry per
//                pipeline stage of the RAM read path; advances only on
//                enabled cycles so it stays aligned with a clk_en-gated RAM.
//  Ports       : clk, rst (async, active high), clk_en,
//                tag_in  - tag of the read accepted this cycle
//                tag_out - tag whose RAM data is valid this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clk_en,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t r_stage [DEPTH];
    rd_tag_t w_din   [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_din[i] = tag_in;
        end else begin : g_body
            assign w_din[i] = r_stage[i-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_stage[i] <= '0;
            end else if (clk_en) begin
                r_stage[i] <= w_din[i];
            end
        end
    end

    assign tag_out = r_stage[DEPTH-1];

endmodule : rd_tag_pipe

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port synchronous RAM between the
//                instruction-fetch path and the load/store path. Load/store
//                normally wins; a starvation counter forces a fetch grant
//                after STARVE_LIMIT consecutive denied fetch cycles. Read
//                data is routed back to its owner through a tag pipeline
//                matching the RAM read latency.
//  Ports       : clk, rst (async, active high), clk_en (global enable)
//                i_fetch_* / o_fetch_*  - fetch read port
//                i_data_*  / o_data_*   - load/store port
//                o_mem_* / i_mem_rdata  - RAM command and read data
//  Options     : define MEM_ARB_STATS_EN to add the 32-bit grant/stall
//                counters o_stat_fetch_grants, o_stat_data_grants and
//                o_stat_fetch_stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 31,
    parameter int DATA_WIDTH   = 31,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,

    input  logic                  i_fetch_req,
    input  logic [ADDR_WIDTH:0]   i_fetch_addr,
    output logic                  o_fetch_ready,
    output logic                  o_fetch_rvalid,
    output logic [DATA_WIDTH:0]   o_fetch_rdata,

    input  logic                  i_data_req,
    input  logic                  i_data_we,
    input  logic [3:0]            i_data_be,
    input  logic [ADDR_WIDTH:0]   i_data_addr,
    input  logic [DATA_WIDTH:0]   i_data_wdata,
    output logic                  o_data_ready,
    output logic                  o_data_rvalid,
    output logic [DATA_WIDTH:0]   o_data_rdata,

    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [3:0]            o_mem_be,
    output logic [ADDR_WIDTH:0]   o_mem_addr,
    output logic [DATA_WIDTH:0]   o_mem_wdata,
    input  logic [DATA_WIDTH:0]   i_mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]           o_stat_fetch_grants,
    output logic [31:0]           o_stat_data_grants,
    output logic [31:0]           o_stat_fetch_stalls
`endif
);

    localparam int              CNT_W      = 4;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [CNT_W-1:0]  w_starve_next;

    logic              w_active;
    logic              w_fetch_grant;
    logic              w_data_grant;
    rd_tag_t           w_tag_in;
    rd_tag_t           w_tag_out;
    logic              w_ret_valid;

    // Reset is folded in so every output reads 0 the moment rst rises,
    // not only after the next clock edge.
    assign w_active = clk_en & ~rst;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= DATA_PRI;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    // ------------------------------------------------------------------
    // Grant, RAM command and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_grant = 1'b0;
        w_data_grant  = 1'b0;
        w_state_next  = r_state;
        w_starve_next = r_starve_cnt;
        o_mem_en      = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_be      = '0;
        o_mem_addr    = '0;
        o_mem_wdata   = '0;
        w_tag_in      = '0;

        if (w_active) begin
            if (i_fetch_req && (!i_data_req || r_state == FETCH_PRI)) begin
                w_fetch_grant = 1'b1;
            end else if (i_data_req) begin
                w_data_grant = 1'b1;
            end
        end

        if (w_fetch_grant) begin
            o_mem_en       = 1'b1;
            o_mem_be       = BE_WORD;
            o_mem_addr     = i_fetch_addr;
            w_tag_in.valid = 1'b1;
            w_tag_in.owner = OWNER_FETCH;
        end else if (w_data_grant) begin
            o_mem_en       = 1'b1;
            o_mem_we       = i_data_we;
            o_mem_be       = i_data_we ? i_data_be : BE_WORD;
            o_mem_addr     = i_data_addr;
            o_mem_wdata    = i_data_we ? i_data_wdata : '0;
            // Stores produce no read data, so they never occupy a tag slot.
            w_tag_in.valid = ~i_data_we;
            w_tag_in.owner = OWNER_DATA;
        end

        if (clk_en) begin
            if (w_fetch_grant || !i_fetch_req) begin
                w_starve_next = '0;
            end else if (r_starve_cnt != STARVE_MAX) begin
                w_starve_next = r_starve_cnt + 4'd1;
            end

            // Switching on the counter's next value lets the forced fetch
            // land on the cycle right after the STARVE_LIMIT-th denial.
            case (r_state)
                DATA_PRI:  if (w_starve_next == STARVE_MAX) w_state_next = FETCH_PRI;
                FETCH_PRI: if (w_fetch_grant)               w_state_next = DATA_PRI;
                default:                                    w_state_next = DATA_PRI;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read-return routing
    // ------------------------------------------------------------------
    rd_tag_pipe #(
        .DEPTH   (READ_LATENCY)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .tag_in  (w_tag_in),
        .tag_out (w_tag_out)
    );

    // A tag stalled at the output while clk_en is low is presented only on
    // the enabled cycle, so each read yields exactly one rvalid pulse.
    assign w_ret_valid    = w_tag_out.valid & clk_en;
    assign o_fetch_rvalid = w_ret_valid & (w_tag_out.owner == OWNER_FETCH);
    assign o_data_rvalid  = w_ret_valid & (w_tag_out.owner == OWNER_DATA);
    assign o_fetch_rdata  = o_fetch_rvalid ? i_mem_rdata : '0;
    assign o_data_rdata   = o_data_rvalid  ? i_mem_rdata : '0;

    assign o_fetch_ready  = w_fetch_grant;
    assign o_data_ready   = w_data_grant;

`ifdef MEM_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Activity counters (wrap naturally at 2^32)
    // ------------------------------------------------------------------
    logic [31:0] r_stat_fetch_grants;
    logic [31:0] r_stat_data_grants;
    logic [31:0] r_stat_fetch_stalls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_fetch_grants <= '0;
            r_stat_data_grants  <= '0;
            r_stat_fetch_stalls <= '0;
        end else begin
            if (w_fetch_grant) begin
                r_stat_fetch_grants <= r_stat_fetch_grants + 32'd1;
            end
            if (w_data_grant) begin
                r_stat_data_grants <= r_stat_data_grants + 32'd1;
            end
            if (clk_en && i_fetch_req && !w_fetch_grant) begin
                r_stat_fetch_stalls <= r_stat_fetch_stalls + 32'd1;
            end
        end
    end

    assign o_stat_fetch_grants = r_stat_fetch_grants;
    assign o_stat_data_grants  = r_stat_data_grants;
    assign o_stat_fetch_stalls = r_stat_fetch_stalls;
`endif

endmodule : mem_port_arbiter

`default_nettype wire
